// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one local command at a time becomes an AW+W+B write or an
// AR+R read; the result is returned on a registered local response port.
module axi_lite_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [2:0]  C_M_AXI_PROT       = 3'b000,
  parameter int unsigned C_ERR_CNT_WIDTH    = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_ERR_CNT_WIDTH-1:0]      err_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state_r;

  // SLVERR/DECERR (resp[1] set) bump the counter, which sticks at all-ones.
  function automatic logic [C_ERR_CNT_WIDTH-1:0] err_next(
    input logic [C_ERR_CNT_WIDTH-1:0] cnt,
    input logic [1:0]                 resp
  );
    if (resp[1] && (cnt != {C_ERR_CNT_WIDTH{1'b1}})) begin
      return cnt + C_ERR_CNT_WIDTH'(1);
    end else begin
      return cnt;
    end
  endfunction

  assign M_AXI_AWPROT = C_M_AXI_PROT;
  assign M_AXI_ARPROT = C_M_AXI_PROT;

  // Transaction sequencer; every local and AXI output is a register of this block.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_r       <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      err_cnt       <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_wdata;
              M_AXI_WSTRB   <= cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state_r       <= WR;
            end else begin
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              state_r       <= RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          // A channel whose VALID is already low has completed its beat.
          if (M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
          end
          if (M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
          end
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state_r      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_write    <= 1'b1;
            rsp_valid    <= 1'b1;
            err_cnt      <= err_next(err_cnt, M_AXI_BRESP);
            state_r      <= RSP;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state_r       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_resp     <= M_AXI_RRESP;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            err_cnt      <= err_next(err_cnt, M_AXI_RRESP);
            state_r      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a 16-register AXI-Lite slave model
// with programmable AW/W/AR ready delays and a reference register model.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [1:0]  err_cnt;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  axi_lite_master #(.C_ERR_CNT_WIDTH(2)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_cnt(err_cnt),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int aw_ctr, w_ctr, ar_ctr;
  int aw_beats = 0, w_beats = 0, withdraw = 0;
  logic [31:0] mem [16];
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  logic        aw_have, w_have, ar_have, aw_pend, w_pend, ar_pend;

  always @(posedge clk) begin
    if (!rstn) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
      aw_have <= 1'b0; w_have <= 1'b0; ar_have <= 1'b0;
      aw_ctr <= 0; w_ctr <= 0; ar_ctr <= 0;
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      aw_pend <= awvalid && !awready;
      w_pend  <= wvalid && !wready;
      ar_pend <= arvalid && !arready;
      if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid))
        withdraw <= withdraw + 1;
      if (awvalid && !awready && !aw_have) begin
        if (aw_ctr >= aw_delay) begin awready <= 1'b1; aw_ctr <= 0; end
        else aw_ctr <= aw_ctr + 1;
      end
      if (awvalid && awready) begin aw_have <= 1'b1; aw_a <= awaddr; aw_beats <= aw_beats + 1; end
      if (wvalid && !wready && !w_have) begin
        if (w_ctr >= w_delay) begin wready <= 1'b1; w_ctr <= 0; end
        else w_ctr <= w_ctr + 1;
      end
      if (wvalid && wready) begin w_have <= 1'b1; w_d <= wdata; w_s <= wstrb; w_beats <= w_beats + 1; end
      if (aw_have && w_have && !bvalid) begin
        aw_have <= 1'b0; w_have <= 1'b0; bvalid <= 1'b1;
        if (aw_a < 32'h40) begin
          bresp <= 2'b00;
          for (int b = 0; b < 4; b++)
            if (w_s[b]) mem[aw_a[5:2]][8*b +: 8] <= w_d[8*b +: 8];
        end else begin
          bresp <= 2'b11;
        end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && !arready && !ar_have) begin
        if (ar_ctr >= ar_delay) begin arready <= 1'b1; ar_ctr <= 0; end
        else ar_ctr <= ar_ctr + 1;
      end
      if (arvalid && arready) begin ar_have <= 1'b1; ar_a <= araddr; end
      if (ar_have && !rvalid) begin
        ar_have <= 1'b0; rvalid <= 1'b1;
        if (ar_a < 32'h40) begin rdata <= mem[ar_a[5:2]]; rresp <= 2'b00; end
        else begin rdata <= 32'h0; rresp <= 2'b11; end
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0, lat = 0, nwr = 0, mdl_err = 0;
  logic [31:0] mdl [16];
  logic [1:0]  got_resp;
  logic [31:0] got_rdata;
  logic        got_write;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    mdl_err = 0;
  endtask

  task automatic model_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] eresp, output logic [31:0] erd);
    if (a < 32'h40) begin
      eresp = 2'b00;
      if (w) for (int b = 0; b < 4; b++) if (s[b]) mdl[a[5:2]][8*b +: 8] = d[8*b +: 8];
      erd = w ? 32'h0 : mdl[a[5:2]];
    end else begin
      eresp = 2'b11;
      erd = 32'h0;
    end
    if (eresp[1] && mdl_err < 3) mdl_err++;
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept_timeout", 64'(n < 100), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'hffff_fff0; cmd_wdata = 32'hdead_beef; cmd_write = ~w;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    lat = n;
    check("rsp_timeout", 64'(rsp_valid), 64'd1);
    got_resp = rsp_resp; got_rdata = rsp_rdata; got_write = rsp_write;
    if (rsp_ready) @(negedge clk);
  endtask

  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0]  eresp;
    logic [31:0] erd;
    model_cmd(w, a, d, s, eresp, erd);
    if (w) nwr++;
    send_cmd(w, a, d, s);
    if (w) check("valid_after_accept_wr", {62'd0, awvalid, wvalid}, 64'd3);
    else   check("valid_after_accept_rd", 64'(arvalid), 64'd1);
    wait_rsp();
    check("rsp_resp", 64'(got_resp), 64'(eresp));
    check("rsp_rdata", 64'(got_rdata), 64'(erd));
    check("rsp_write", 64'(got_write), 64'(w));
    check("err_cnt", 64'(err_cnt), 64'(mdl_err));
  endtask

  typedef struct { int aw; int w; int lat; } dly_t;
  dly_t dly_tab [3] = '{'{3, 0, 7}, '{0, 3, 7}, '{5, 5, 9}};
  logic [1:0] sat_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    int awb, wb;
    logic [31:0] a, d;
    logic [1:0]  hold_resp;
    logic [31:0] hold_rdata;
    logic        w;

    model_clear();
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_addr_data", {awaddr, wdata}, 64'd0);
    check("rst_prot", {58'd0, awprot, arprot}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // write then read back a strobed word at 0x08
    do_cmd(1'b1, 32'h0000_0008, 32'haa00_0055, 4'b1001);
    check("wr_latency", 64'(lat), 64'd4);
    check("wr_awaddr_held", 64'(awaddr), 64'h8);
    do_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    check("rd_latency", 64'(lat), 64'd4);
    check("rd_data_08", 64'(got_rdata), 64'haa00_0055);

    // delayed AW/W readies: one beat each, latency stretches by the larger delay
    for (int i = 0; i < 3; i++) begin
      aw_delay = dly_tab[i].aw; w_delay = dly_tab[i].w;
      awb = aw_beats; wb = w_beats;
      do_cmd(1'b1, 32'h0000_0010 + 32'(4 * i), 32'h0102_0304 * 32'(i + 1), 4'hf);
      check("dly_latency", 64'(lat), 64'(dly_tab[i].lat));
      check("dly_beats", {32'(aw_beats - awb), 32'(w_beats - wb)}, {32'd1, 32'd1});
    end
    aw_delay = 0; w_delay = 0;

    // decode errors saturate a 2-bit counter at 3
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 32'h0100_0000, 32'h1234_5678, 4'hf);
      check("decerr_resp", 64'(got_resp), 64'd3);
      check("err_sat", 64'(err_cnt), 64'(sat_tab[i]));
    end

    // response stalled by rsp_ready=0
    rsp_ready = 1'b0;
    do_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    hold_resp = got_resp; hold_rdata = got_rdata;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h7777_7777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_fields", {29'd0, rsp_valid, rsp_write, rsp_resp, rsp_rdata},
            {29'd0, 1'b1, 1'b0, hold_resp, hold_rdata});
      check("stall_no_axi", {60'd0, cmd_ready, awvalid, wvalid, arvalid}, 64'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // reset while both write channels are pending
    aw_delay = 5; w_delay = 5;
    send_cmd(1'b1, 32'h0000_000C, 32'h5555_aaaa, 4'hf);
    @(negedge clk);
    check("pend_valids", {62'd0, awvalid, wvalid}, 64'd3);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_valids", {61'd0, awvalid, wvalid, rsp_valid}, 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    rstn = 1'b1;
    aw_delay = 0; w_delay = 0;
    model_clear();
    @(negedge clk);
    do_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    do_cmd(1'b1, 32'h0000_000C, 32'h0bad_f00d, 4'hf);
    do_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    check("post_rst_rd", 64'(got_rdata), 64'h0bad_f00d);

    // mixed random traffic against the register model
    for (int i = 0; i < 300; i++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 79));
      d = $urandom;
      do_cmd(w, a, d, 4'($urandom_range(0, 15)));
    end
    check("beat_totals", {32'(aw_beats), 32'(w_beats)}, {32'(nwr), 32'(nwr)});
    check("no_withdraw", 64'(withdraw), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
